i2c_mst_ctrl: RTL and testbench
===============================

I2C_MST_CTRL -- requirements
Module: i2c_mst_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per quarter SCL period; legal range 2..255.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  a command is presented.
REQ-005 cmd_ready  output  1  the engine accepts a command this cycle.
REQ-006 cmd_op  input  2  operation code: 0 START, 1 WRITE, 2 READ, 3 STOP.
REQ-007 cmd_wdata  input  8  byte to send on WRITE.
REQ-008 cmd_nack  input  1  on READ, the engine sends NACK when this is 1 and ACK when it is 0.
REQ-009 done  output  1  one-cycle pulse when a command completes.
REQ-010 rdata  output  8  byte received by the last READ; held until the next READ completes.
REQ-011 ack_n  output  1  ACK bit sampled on the last WRITE (1 = NACK); held until the next WRITE completes.
REQ-012 busy  output  1  high from command accept until done.
REQ-013 scl_i, sda_i  input  1 each  bus line levels returned from the pads.
REQ-014 scl_oe_n, sda_oe_n  output  1 each  open-drain controls: 0 pulls the line low, 1 releases it.

Function
REQ-015 A command transfers on a clk edge where cmd_valid and cmd_ready are both 1; cmd_ready = !busy; the engine captures cmd_op, cmd_wdata and cmd_nack on that edge.
REQ-016 Quarter counter: counts 0..CLK_DIV-1 and advances the phase on wrap; a bit is exactly 4 quarters (Q0..Q3).
REQ-017 FSM states: IDLE, START, BIT, ACK, STOP.
REQ-018 Transitions:
  - IDLE -> START/BIT/STOP on accept.
  - BIT -> ACK after 8 bits.
  - ACK, START and STOP -> IDLE, with done pulsed in the cycle the state is entered.
REQ-019 START:
  - Q0, Q1: SDA and SCL released.
  - Q2: SDA low, SCL released.
  - Q3: SDA low, SCL low.
  - START is legal from bus-idle and as a repeated start.
REQ-020 STOP:
  - Q0: SCL low, SDA low.
  - Q1: SCL released, SDA low.
  - Q2, Q3: both released.
REQ-021 BIT and ACK quarters:
  - Q0, Q1: SCL low; SDA data is changed only at the start of Q0.
  - Q2, Q3: SCL released.
REQ-022 WRITE drives data MSB first, with sda_oe_n = the data bit; during ACK, SDA is released and ack_n = sda_i sampled at the last cycle of Q2.
REQ-023 READ releases SDA for 8 bits and shifts sda_i in, MSB first, at the last cycle of Q2; during ACK, sda_oe_n = cmd_nack.
REQ-024 Between commands, SCL stays low after START/BIT/ACK and both lines stay released after STOP; the engine never changes SDA while SCL is released except inside START and STOP.
REQ-025 Latency from accept to done:
  - START and STOP: 4·CLK_DIV cycles.
  - WRITE and READ: 36·CLK_DIV cycles.
  - With stretching enabled (REQ-030), the added stall cycles extend these figures.
REQ-026 cmd_valid while busy is ignored; it is not queued.

Reset
REQ-027 While rst is high, the FSM is in IDLE and the counters, shift register, rdata and ack_n are 0.
REQ-028 While rst is high, outputs are: scl_oe_n = 1, sda_oe_n = 1, cmd_ready = 1, busy = 0, done = 0.
REQ-029 Reset asserted mid-command releases both lines immediately and asynchronously; no STOP is generated and no done is issued.

Configuration
REQ-030 With I2C_MST_STRETCH_EN defined: in any Q2, the quarter counter holds while scl_oe_n = 1 and scl_i = 0, and resumes the cycle after scl_i reads 1.
REQ-031 Without I2C_MST_STRETCH_EN: scl_i is unused and timing is exactly per REQ-025.

Structure
REQ-032 The shared package i2c_mst_pkg holds the opcode constants (OP_START, OP_WRITE, OP_READ, OP_STOP) and the FSM state enumeration.
REQ-033 The quarter-period timer is a sub-module, i2c_mst_qtimer, with inputs enable and stall and outputs q_idx[1:0] and q_last.

Verification
REQ-034 CLK_DIV=4, START: done 16 cycles after accept; SDA falls while SCL is high.
REQ-035 WRITE 0xA5 with the slave model ACKing: SDA bit sequence 1,0,1,0,0,1,0,1; ack_n=0; done 144 cycles after accept.
REQ-036 READ with the slave returning 0x3C and cmd_nack=1: rdata=0x3C and SDA is released during the 9th clock.
REQ-037 STOP after WRITE with the slave NACKing: ack_n=1; SDA rises while SCL is high; both lines end released.
REQ-038 rst asserted in bit 4 of a WRITE: scl_oe_n and sda_oe_n go to 1 in the same cycle, busy=0, and no done pulse.
REQ-039 I2C_MST_STRETCH_EN defined, slave holds SCL low for 10 cycles in bit 0: done delayed by exactly 10 cycles.

Source files
------------

// File: rtl/i2c_mst_pkg.sv
// Shared opcodes and FSM state encoding for the I2C master engine.
package i2c_mst_pkg;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_e;

endpackage

// File: rtl/i2c_mst_qtimer.sv
// Quarter-period timer: CLK_DIV clocks per quarter, four quarters per bit.
module i2c_mst_qtimer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       stall,
  output logic [1:0] q_idx,
  output logic       q_last
);
  logic [7:0] cnt;

  assign q_last = (cnt == 8'(CLK_DIV - 1));

  // Disabled means parked at Q0 so the next command starts on a clean quarter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      q_idx <= '0;
    end else if (!enable) begin
      cnt   <= '0;
      q_idx <= '0;
    end else if (!stall) begin
      if (q_last) begin
        cnt   <= '0;
        q_idx <= q_idx + 2'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_mst_ctrl.sv
// Byte-level I2C master: executes START / WRITE / READ / STOP commands one at a time.
// Define I2C_MST_STRETCH_EN to let a slave stretch SCL (timer holds in Q2 while SCL is held low).
module i2c_mst_ctrl
  import i2c_mst_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_n,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_n,
  output logic       sda_oe_n
);
  state_e     state_q, state_d;
  logic [1:0] q_idx;
  logic       q_last, stall, q_sample, bit_end, tmr_en;
  logic [1:0] op_q;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic       nack_q, ack_smp, scl_idle, sda_idle, is_read;

  assign is_read   = (op_q == OP_READ);
  assign q_sample  = (q_idx == 2'd2) && q_last && !stall;
  assign bit_end   = (q_idx == 2'd3) && q_last;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign tmr_en    = (state_q != S_IDLE);

`ifdef I2C_MST_STRETCH_EN
  assign stall = (q_idx == 2'd2) && scl_oe_n && !scl_i;
`else
  logic scl_unused;
  assign scl_unused = scl_i;
  assign stall      = 1'b0;
`endif

  i2c_mst_qtimer #(.CLK_DIV(CLK_DIV)) u_qtimer (
    .clk    (clk),
    .rst    (rst),
    .enable (tmr_en),
    .stall  (stall),
    .q_idx  (q_idx),
    .q_last (q_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Lines are decoded from state so that reset releases them without a clock edge.
  always_comb begin
    state_d  = state_q;
    scl_oe_n = scl_idle;
    sda_oe_n = sda_idle;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_START: state_d = S_START;
            OP_STOP:  state_d = S_STOP;
            default:  state_d = S_BIT;
          endcase
        end
      end
      S_START: begin
        scl_oe_n = (q_idx != 2'd3);
        sda_oe_n = !q_idx[1];
        if (bit_end) state_d = S_IDLE;
      end
      S_STOP: begin
        scl_oe_n = (q_idx != 2'd0);
        sda_oe_n = q_idx[1];
        if (bit_end) state_d = S_IDLE;
      end
      S_BIT: begin
        scl_oe_n = q_idx[1];
        sda_oe_n = is_read ? 1'b1 : sh[7];
        if (bit_end && bit_cnt == 3'd7) state_d = S_ACK;
      end
      S_ACK: begin
        scl_oe_n = q_idx[1];
        sda_oe_n = is_read ? nack_q : 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // scl_idle/sda_idle park the bus between commands at whatever the last command left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      op_q     <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      nack_q   <= 1'b0;
      ack_smp  <= 1'b0;
      rdata    <= '0;
      ack_n    <= 1'b0;
      scl_idle <= 1'b1;
      sda_idle <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            sh      <= cmd_wdata;
            nack_q  <= cmd_nack;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            done     <= 1'b1;
            scl_idle <= 1'b0;
            sda_idle <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            done     <= 1'b1;
            scl_idle <= 1'b1;
            sda_idle <= 1'b1;
          end
        end
        S_BIT: begin
          if (q_sample && is_read) sh <= {sh[6:0], sda_i};
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (!is_read) sh <= {sh[6:0], 1'b0};
          end
        end
        S_ACK: begin
          if (q_sample) ack_smp <= sda_i;
          if (bit_end) begin
            done     <= 1'b1;
            scl_idle <= 1'b0;
            sda_idle <= is_read ? nack_q : 1'b1;
            if (is_read) rdata <= sh;
            else         ack_n <= ack_smp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mst_ctrl.sv
// Self-checking bench for i2c_mst_ctrl: open-drain bus with a byte-level slave model.
module tb_i2c_mst_ctrl;
  import i2c_mst_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int LIMIT   = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_nack;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       done, ack_n, busy;
  logic [7:0] rdata;
  logic       scl_i, sda_i, scl_oe_n, sda_oe_n;

  int n_checks = 0;
  int n_fail   = 0;

  // slave model: mode 0 idle, 1 write target (ACKs with slave_ack), 2 read source
  int         slave_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  logic       slave_ack  = 1'b0;
  logic       slave_scl  = 1'b1;
  logic       slave_sda;
  int         fall_base  = 0;

  // bus monitor state (written only by the monitor process)
  int   fall_total  = 0;
  int   n_fall_hi   = 0;
  int   n_rise_hi   = 0;
  int   done_total  = 0;
  logic rise_sda[$];
  logic rise_oe[$];
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  logic [7:0] exp_rdata = 8'h00;
  logic       exp_ack_n = 1'b0;

  always #5 clk = ~clk;

  assign scl_i = scl_oe_n & slave_scl;
  assign sda_i = sda_oe_n & slave_sda;

  always_comb begin
    int k;
    k = fall_total - fall_base;
    slave_sda = 1'b1;
    if (slave_mode == 2 && k >= 0 && k < 8) slave_sda = slave_byte[7 - k];
    else if (slave_mode == 1 && k == 8)     slave_sda = slave_ack;
  end

  always @(negedge clk) begin
    if (prev_scl && scl_i && prev_sda && !sda_i) n_fall_hi <= n_fall_hi + 1;
    if (prev_scl && scl_i && !prev_sda && sda_i) n_rise_hi <= n_rise_hi + 1;
    if (!prev_scl && scl_i) begin
      rise_sda.push_back(sda_i);
      rise_oe.push_back(sda_oe_n);
    end
    if (prev_scl && !scl_i) fall_total <= fall_total + 1;
    if (done) done_total <= done_total + 1;
    prev_scl <= scl_i;
    prev_sda <= sda_i;
  end

  i2c_mst_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wdata (cmd_wdata),
    .cmd_nack  (cmd_nack),
    .done      (done),
    .rdata     (rdata),
    .ack_n     (ack_n),
    .busy      (busy),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_oe_n  (scl_oe_n),
    .sda_oe_n  (sda_oe_n)
  );

  // Issue one command; lat = clock edges from the accept edge to the edge that raises done.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk,
                         output int lat, output int rbase);
    @(negedge clk);
    cmd_op = op; cmd_wdata = wd; cmd_nack = nk; cmd_valid = 1'b1;
    @(posedge clk);
    fall_base = fall_total;
    rbase     = rise_sda.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  function automatic logic [7:0] sda_byte(input int rb);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7 - j] = (rb + j < rise_sda.size()) ? rise_sda[rb + j] : 1'bx;
    return b;
  endfunction

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 8'h00; cmd_nack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (scl_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_scl got %b exp 1", scl_oe_n); end
    n_checks++; if (sda_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_sda got %b exp 1", sda_oe_n); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    n_checks++; if (ack_n !== 1'b0) begin n_fail++; $display("FAIL reset_ack_n got %b exp 0", ack_n); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start;
    int lat, rb, f0;
    f0 = n_fall_hi;
    slave_mode = 0;
    run_cmd(OP_START, 8'h00, 1'b0, lat, rb);
    n_checks++; if (lat !== 4 * CLK_DIV) begin n_fail++; $display("FAIL start_latency got %0d exp %0d", lat, 4 * CLK_DIV); end
    n_checks++; if (n_fall_hi - f0 !== 1) begin n_fail++; $display("FAIL start_sda_fall_scl_high got %0d exp 1", n_fall_hi - f0); end
    n_checks++; if ({scl_oe_n, sda_oe_n} !== 2'b00) begin n_fail++; $display("FAIL start_hold got %b exp 00", {scl_oe_n, sda_oe_n}); end
  endtask

  task automatic test_write;
    int lat, rb, h0;
    h0 = n_fall_hi + n_rise_hi;
    slave_mode = 1; slave_ack = 1'b0;
    run_cmd(OP_WRITE, 8'hA5, 1'b0, lat, rb);
    exp_ack_n = 1'b0;
    n_checks++; if (lat !== 36 * CLK_DIV) begin n_fail++; $display("FAIL write_latency got %0d exp %0d", lat, 36 * CLK_DIV); end
    n_checks++; if (sda_byte(rb) !== 8'hA5) begin n_fail++; $display("FAIL write_sda_bits got %h exp a5", sda_byte(rb)); end
    n_checks++; if (ack_n !== exp_ack_n) begin n_fail++; $display("FAIL write_ack_n got %b exp %b", ack_n, exp_ack_n); end
    n_checks++; if (n_fall_hi + n_rise_hi - h0 !== 0) begin n_fail++; $display("FAIL write_sda_change_scl_high got %0d exp 0", n_fall_hi + n_rise_hi - h0); end
    n_checks++; if (scl_oe_n !== 1'b0) begin n_fail++; $display("FAIL write_scl_hold got %b exp 0", scl_oe_n); end
  endtask

  task automatic test_read;
    int lat, rb, h0;
    h0 = n_fall_hi + n_rise_hi;
    slave_mode = 2; slave_byte = 8'h3C;
    run_cmd(OP_READ, 8'h00, 1'b1, lat, rb);
    exp_rdata = 8'h3C;
    n_checks++; if (lat !== 36 * CLK_DIV) begin n_fail++; $display("FAIL read_latency got %0d exp %0d", lat, 36 * CLK_DIV); end
    n_checks++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL read_rdata got %h exp %h", rdata, exp_rdata); end
    n_checks++; if (rise_oe.size() < rb + 9 || rise_oe[rb + 8] !== 1'b1 || rise_sda[rb + 8] !== 1'b1) begin
      n_fail++; $display("FAIL read_nack_released got size %0d exp 9th clock sda released", rise_oe.size() - rb);
    end
    n_checks++; if (n_fall_hi + n_rise_hi - h0 !== 0) begin n_fail++; $display("FAIL read_sda_change_scl_high got %0d exp 0", n_fall_hi + n_rise_hi - h0); end
    n_checks++; if (ack_n !== exp_ack_n) begin n_fail++; $display("FAIL read_ack_n_held got %b exp %b", ack_n, exp_ack_n); end
  endtask

  task automatic test_stop;
    int lat, rb, r0, f0;
    slave_mode = 1; slave_ack = 1'b1;
    run_cmd(OP_WRITE, 8'h42, 1'b0, lat, rb);
    exp_ack_n = 1'b1;
    n_checks++; if (ack_n !== exp_ack_n) begin n_fail++; $display("FAIL stop_write_nack got %b exp 1", ack_n); end
    n_checks++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL stop_rdata_held got %h exp %h", rdata, exp_rdata); end
    r0 = n_rise_hi; f0 = n_fall_hi;
    slave_mode = 0;
    run_cmd(OP_STOP, 8'h00, 1'b0, lat, rb);
    n_checks++; if (lat !== 4 * CLK_DIV) begin n_fail++; $display("FAIL stop_latency got %0d exp %0d", lat, 4 * CLK_DIV); end
    n_checks++; if (n_rise_hi - r0 !== 1 || n_fall_hi - f0 !== 0) begin
      n_fail++; $display("FAIL stop_sda_rise_scl_high got rise %0d fall %0d exp 1 0", n_rise_hi - r0, n_fall_hi - f0);
    end
    repeat (5) @(negedge clk);
    n_checks++; if ({scl_i, sda_i, scl_oe_n, sda_oe_n} !== 4'b1111) begin
      n_fail++; $display("FAIL stop_released got %b exp 1111", {scl_i, sda_i, scl_oe_n, sda_oe_n});
    end
  endtask

  task automatic test_busy_ignored;
    int d0;
    slave_mode = 0;
    @(negedge clk);
    cmd_op = OP_START; cmd_valid = 1'b1;
    @(posedge clk);
    d0 = done_total;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL busy_flags got %b exp 01", {cmd_ready, busy}); end
    cmd_op = OP_STOP; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL busy_done_count got %0d exp 1", done_total - d0); end
    n_checks++; if ({busy, scl_oe_n} !== 2'b00) begin n_fail++; $display("FAIL busy_not_queued got %b exp 00", {busy, scl_oe_n}); end
  endtask

  task automatic test_random;
    int lat, rb, h0;
    logic [7:0] b;
    logic a, rd;
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(0, 1));
      b  = 8'($urandom_range(0, 255));
      a  = 1'($urandom_range(0, 1));
      h0 = n_fall_hi + n_rise_hi;
      if (rd) begin
        slave_mode = 2; slave_byte = b;
        run_cmd(OP_READ, 8'($urandom_range(0, 255)), a, lat, rb);
        exp_rdata = b;
      end else begin
        slave_mode = 1; slave_ack = a;
        run_cmd(OP_WRITE, b, 1'b0, lat, rb);
        exp_ack_n = a;
        n_checks++; if (sda_byte(rb) !== b) begin n_fail++; $display("FAIL rand_sda_bits[%0d] got %h exp %h", i, sda_byte(rb), b); end
      end
      n_checks++; if (lat !== 36 * CLK_DIV) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat, 36 * CLK_DIV); end
      n_checks++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d] got %h exp %h", i, rdata, exp_rdata); end
      n_checks++; if (ack_n !== exp_ack_n) begin n_fail++; $display("FAIL rand_ack_n[%0d] got %b exp %b", i, ack_n, exp_ack_n); end
      n_checks++; if (n_fall_hi + n_rise_hi - h0 !== 0) begin n_fail++; $display("FAIL rand_sda_change[%0d] got %0d exp 0", i, n_fall_hi + n_rise_hi - h0); end
    end
  endtask

`ifdef I2C_MST_STRETCH_EN
  task automatic test_stretch;
    int lat, rb, c;
    slave_mode = 1; slave_ack = 1'b0;
    slave_scl = 1'b0;
    fork
      run_cmd(OP_WRITE, 8'h5A, 1'b0, lat, rb);
      begin
        c = 0;
        do begin @(negedge clk); c++; end while (!scl_oe_n && c < 200);
        repeat (10) @(negedge clk);
        slave_scl = 1'b1;
      end
    join
    exp_ack_n = 1'b0;
    n_checks++; if (lat !== 36 * CLK_DIV + 10) begin n_fail++; $display("FAIL stretch_latency got %0d exp %0d", lat, 36 * CLK_DIV + 10); end
    n_checks++; if (sda_byte(rb) !== 8'h5A) begin n_fail++; $display("FAIL stretch_sda_bits got %h exp 5a", sda_byte(rb)); end
  endtask
`endif

  task automatic test_reset_mid;
    int d0;
    slave_mode = 1; slave_ack = 1'b0;
    @(negedge clk);
    cmd_op = OP_WRITE; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    @(posedge clk);
    fall_base = fall_total;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (16 * CLK_DIV + 1) @(negedge clk);
    n_checks++; if ({busy, scl_oe_n, sda_oe_n} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_pre got %b exp 100", {busy, scl_oe_n, sda_oe_n});
    end
    d0 = done_total;
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({scl_oe_n, sda_oe_n, busy, done} !== 4'b1100) begin
      n_fail++; $display("FAIL rstmid_async got %b exp 1100", {scl_oe_n, sda_oe_n, busy, done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rdata = 8'h00; exp_ack_n = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++; if (done_total !== d0) begin n_fail++; $display("FAIL rstmid_no_done got %0d exp %0d", done_total, d0); end
    n_checks++; if ({cmd_ready, scl_oe_n, sda_oe_n} !== 3'b111) begin
      n_fail++; $display("FAIL rstmid_idle got %b exp 111", {cmd_ready, scl_oe_n, sda_oe_n});
    end
    n_checks++; if ({rdata, ack_n} !== {exp_rdata, exp_ack_n}) begin
      n_fail++; $display("FAIL rstmid_regs got %h exp %h", {rdata, ack_n}, {exp_rdata, exp_ack_n});
    end
  endtask

  initial begin
    test_reset;
    test_start;
    test_write;
    test_read;
    test_stop;
    test_busy_ignored;
    test_start;
    test_random;
`ifdef I2C_MST_STRETCH_EN
    test_stretch;
`endif
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
